sync_pulse_generator_mc: RTL and testbench

Parametrised multi-channel sync generator. It is the successor to the fixed eight-output sync fan-out (sync_spwa..h, sync_in/sync_out) in the MebX system. It produces a repeating sync cycle: one master pulse followed by N-1 normal pulses. The cycle is either self-timed or slaved to an external sync input. It fans out to N_CH individually enabled channels with selectable polarity and is configured by the Nios over a small Avalon-MM slave.

---
 rtl/sync_pulse_generator_mc.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sync_pulse_generator_mc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pulse_generator_mc.sv
// sync_pulse_generator_mc
// Multi-channel sync generator. Emits a repeating cycle of one master pulse
// followed by N_PULSES-1 normal pulses, either self-timed from PERIOD or
// slaved to the rising edges of sync_in. The output fans out to N_CH
// individually enabled channels with selectable polarity. Configuration
// comes through a small Avalon-MM slave. CNT_W must not exceed 32.
module sync_pulse_generator_mc #(
   parameter int N_CH  = 8,
   parameter int CNT_W = 32,
   parameter int IDX_W = 4
) (
   input  logic            clk50_clk,
   input  logic            rst_reset_n,
   input  logic [2:0]      avs_address,
   input  logic            avs_read,
   output logic [31:0]     avs_readdata,
   input  logic            avs_write,
   input  logic [31:0]     avs_writedata,
   input  logic            sync_in,
   output logic            sync_out,
   output logic [N_CH-1:0] sync_ch,
   output logic            irq
);

   localparam logic [2:0] ADDR_CTRL      = 3'd0;
   localparam logic [2:0] ADDR_MASTER_W  = 3'd1;
   localparam logic [2:0] ADDR_PULSE_W   = 3'd2;
   localparam logic [2:0] ADDR_PERIOD    = 3'd3;
   localparam logic [2:0] ADDR_N_PULSES  = 3'd4;
   localparam logic [2:0] ADDR_CH_EN     = 3'd5;
   localparam logic [2:0] ADDR_STATUS    = 3'd6;
   localparam logic [2:0] ADDR_CYCLE_CNT = 3'd7;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_EDGE,
      ST_ACTIVE
   } state_t;

   // Programmed (bus-visible) configuration
   logic             run, ext_mode, invert, irq_en;
   logic [CNT_W-1:0] master_w, pulse_w, period;
   logic [IDX_W-1:0] n_pulses;
   logic [N_CH-1:0]  ch_en;

   // Active copy used by the cycle in progress
   logic [CNT_W-1:0] act_master_w, act_pulse_w, act_period;
   logic [IDX_W-1:0] act_last_idx;
   logic             act_ext;

   // Sequencer state
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             pulse;
   logic             run_q;
   logic             cfg_err;
   logic [31:0]      cycle_cnt;

   // External sync synchroniser and edge-detect history
   logic sync_s1, sync_s2, sync_s3;

   // Derived combinational terms
   logic             wr_ctrl, stop_wr, start, edge_det, slot_end;
   logic [IDX_W-1:0] ld_last_idx;
   logic [CNT_W-1:0] cnt_inc, cur_w, step_w, wrap_w, start_w;
   logic [31:0]      status, rd_mux;

   // Pulse width actually used: clamped so each internally timed slot keeps
   // at least one inactive tick; external slots have no period to clamp to.
   function automatic logic [CNT_W-1:0] eff_width(input logic [CNT_W-1:0] w,
                                                  input logic [CNT_W-1:0] per,
                                                  input logic             ext);
      logic [CNT_W-1:0] lim;
      logic [CNT_W-1:0] res;
      lim = per - CNT_ONE;
      res = w;
      if (!ext && (w > lim)) res = lim;
      return res;
   endfunction

   // Decode bus strobes, slot timing and the widths needed for the next tick
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wr_ctrl     = avs_write && (avs_address == ADDR_CTRL);
      stop_wr     = wr_ctrl && !avs_writedata[0];
      start       = run && !run_q && !stop_wr;
      edge_det    = sync_s2 && !sync_s3;
      ld_last_idx = (n_pulses == '0) ? '0 : (n_pulses - IDX_ONE);
      slot_end    = act_ext ? edge_det : (cnt == (act_period - CNT_ONE));
      cnt_inc     = (&cnt) ? cnt : (cnt + CNT_ONE);
      cur_w       = eff_width((idx == '0) ? act_master_w : act_pulse_w, act_period, act_ext);
      step_w      = eff_width(act_pulse_w, act_period, act_ext);
      wrap_w      = eff_width(master_w, period, act_ext);
      start_w     = eff_width(master_w, period, 1'b0);
   end

   // Two-flop synchroniser on sync_in plus one history flop for edge detection
   always_ff @(posedge clk50_clk or negedge rst_reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_reset_n) begin
         sync_s1 <= 1'b0;
         sync_s2 <= 1'b0;
         sync_s3 <= 1'b0;
      end else begin
         sync_s1 <= sync_in;
         sync_s2 <= sync_s1;
         sync_s3 <= sync_s2;
      end
   end

   // Bus writes into the programmed configuration
   always_ff @(posedge clk50_clk or negedge rst_reset_n) begin
      if (!rst_reset_n) begin
         run      <= 1'b0;
         ext_mode <= 1'b0;
         invert   <= 1'b0;
         irq_en   <= 1'b0;
         master_w <= '0;
         pulse_w  <= '0;
         period   <= '0;
         n_pulses <= '0;
         ch_en    <= '0;
      end else if (avs_write) begin
         case (avs_address)
            ADDR_CTRL: begin
               run      <= avs_writedata[0];
               ext_mode <= avs_writedata[1];
               invert   <= avs_writedata[2];
               irq_en   <= avs_writedata[3];
            end
            ADDR_MASTER_W: master_w <= avs_writedata[CNT_W-1:0];
            ADDR_PULSE_W:  pulse_w  <= avs_writedata[CNT_W-1:0];
            ADDR_PERIOD:   period   <= avs_writedata[CNT_W-1:0];
            ADDR_N_PULSES: n_pulses <= avs_writedata[IDX_W-1:0];
            ADDR_CH_EN:    ch_en    <= avs_writedata[N_CH-1:0];
            default: ;
         endcase
      end
   end

   // Sequencer: start/stop, slot counting, index advance, shadow load and irq.
   // A write that clears run freezes the sequencer for its one remaining
   // cycle, so a stop coinciding with a cycle boundary suppresses the load.
   always_ff @(posedge clk50_clk or negedge rst_reset_n) begin
      if (!rst_reset_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         idx          <= '0;
         pulse        <= 1'b0;
         irq          <= 1'b0;
         run_q        <= 1'b0;
         cfg_err      <= 1'b0;
         cycle_cnt    <= '0;
         act_master_w <= '0;
         act_pulse_w  <= '0;
         act_period   <= '0;
         act_last_idx <= '0;
         act_ext      <= 1'b0;
      end else begin
         irq   <= 1'b0;
         run_q <= run;
         if (state == ST_IDLE) begin
            pulse <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
            if (start) begin
               cycle_cnt    <= '0;
               act_master_w <= master_w;
               act_pulse_w  <= pulse_w;
               act_period   <= period;
               act_last_idx <= ld_last_idx;
               act_ext      <= ext_mode;
               if (ext_mode) begin
                  cfg_err <= 1'b0;
                  state   <= ST_WAIT_EDGE;
               end else if (period < CNT_TWO) begin
                  cfg_err <= 1'b1;
               end else begin
                  cfg_err <= 1'b0;
                  state   <= ST_ACTIVE;
                  pulse   <= (start_w != '0);
                  irq     <= irq_en;
               end
            end
         end else if (!run) begin
            state <= ST_IDLE;
            pulse <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
         end else if (stop_wr) begin
            state <= state;
         end else if (state == ST_WAIT_EDGE) begin
            if (edge_det) begin
               state <= ST_ACTIVE;
               cnt   <= '0;
               idx   <= '0;
               pulse <= (act_master_w != '0);
               irq   <= irq_en;
            end
         end else if (slot_end) begin
            cnt <= '0;
            if (idx == act_last_idx) begin
               idx          <= '0;
               cycle_cnt    <= cycle_cnt + 32'd1;
               act_master_w <= master_w;
               act_pulse_w  <= pulse_w;
               act_period   <= period;
               act_last_idx <= ld_last_idx;
               if (!act_ext && (period < CNT_TWO)) begin
                  cfg_err <= 1'b1;
                  state   <= ST_IDLE;
                  pulse   <= 1'b0;
               end else begin
                  cfg_err <= 1'b0;
                  pulse   <= (wrap_w != '0);
                  irq     <= irq_en;
               end
            end else begin
               idx   <= idx + IDX_ONE;
               pulse <= (step_w != '0);
            end
         end else begin
            cnt   <= cnt_inc;
            pulse <= (cnt_inc < cur_w);
         end
      end
   end

   // Read multiplexer over the current register values
   always_comb begin
      status             = '0;
      status[0]          = (state != ST_IDLE);
      status[1]          = cfg_err;
      status[8 +: IDX_W] = idx;
      rd_mux             = '0;
      case (avs_address)
         ADDR_CTRL:      rd_mux = {28'd0, irq_en, invert, ext_mode, run};
         ADDR_MASTER_W:  rd_mux = 32'(master_w);
         ADDR_PULSE_W:   rd_mux = 32'(pulse_w);
         ADDR_PERIOD:    rd_mux = 32'(period);
         ADDR_N_PULSES:  rd_mux = 32'(n_pulses);
         ADDR_CH_EN:     rd_mux = 32'(ch_en);
         ADDR_STATUS:    rd_mux = status;
         ADDR_CYCLE_CNT: rd_mux = cycle_cnt;
         default:        rd_mux = '0;
      endcase
   end

   // Registered read data; a same-cycle write is not yet visible here
   always_ff @(posedge clk50_clk or negedge rst_reset_n) begin
      if (!rst_reset_n) begin
         avs_readdata <= '0;
      end else if (avs_read) begin
         avs_readdata <= rd_mux;
      end
   end

   // Polarity and channel enables act immediately on the registered pulse
   assign sync_out = pulse ^ invert;
   assign sync_ch  = {N_CH{sync_out}} & ch_en;

endmodule

// File: tb/tb_sync_pulse_generator_mc.sv
// tb_sync_pulse_generator_mc
// Directed bench for sync_pulse_generator_mc. Inputs change on the falling
// edge; outputs are sampled on the falling edge after each rising edge.
module tb_sync_pulse_generator_mc;

   localparam int N_CH = 8;

   localparam logic [2:0] A_CTRL      = 3'd0;
   localparam logic [2:0] A_MASTER_W  = 3'd1;
   localparam logic [2:0] A_PULSE_W   = 3'd2;
   localparam logic [2:0] A_PERIOD    = 3'd3;
   localparam logic [2:0] A_N_PULSES  = 3'd4;
   localparam logic [2:0] A_CH_EN     = 3'd5;
   localparam logic [2:0] A_STATUS    = 3'd6;
   localparam logic [2:0] A_CYCLE_CNT = 3'd7;

   logic            clk50_clk = 1'b0;
   logic            rst_reset_n;
   logic [2:0]      avs_address;
   logic            avs_read;
   logic [31:0]     avs_readdata;
   logic            avs_write;
   logic [31:0]     avs_writedata;
   logic            sync_in;
   logic            sync_out;
   logic [N_CH-1:0] sync_ch;
   logic            irq;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk50_clk = ~clk50_clk;

   sync_pulse_generator_mc #(
      .N_CH  (N_CH),
      .CNT_W (32),
      .IDX_W (4)
   ) dut (
      .clk50_clk     (clk50_clk),
      .rst_reset_n   (rst_reset_n),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .sync_in       (sync_in),
      .sync_out      (sync_out),
      .sync_ch       (sync_ch),
      .irq           (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called on a falling edge; the write is taken on the next rising edge.
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk50_clk);
      avs_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk50_clk);
      avs_read    = 1'b0;
      d           = avs_readdata;
   endtask

   // Expected pulse level at tick t after an internal-mode start.
   function automatic bit model_pulse(input int t, input int per, input int npul,
                                      input int mw0, input int mw1, input int pw);
      int cyc;
      int slot;
      int c;
      int w;
      cyc  = t / (per * npul);
      slot = (t / per) % npul;
      c    = t % per;
      w    = (slot == 0) ? ((cyc == 0) ? mw0 : mw1) : pw;
      if (w > per - 1) w = per - 1;
      return c < w;
   endfunction

   task automatic chk_int(input string tag, input int t, input int per, input int npul,
                          input int mw0, input int mw1, input int pw,
                          input logic [N_CH-1:0] mask, input bit irq_on);
      bit p;
      p = model_pulse(t, per, npul, mw0, mw1, pw);
      check($sformatf("%s_ch_t%0d", tag, t), 32'(sync_ch), p ? 32'(mask) : 32'd0);
      check($sformatf("%s_irq_t%0d", tag, t), 32'(irq),
            32'(irq_on && ((t % (per * npul)) == 0)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int w;

      rst_reset_n   = 1'b0;
      avs_address   = '0;
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      avs_writedata = '0;
      sync_in       = 1'b0;
      repeat (3) @(negedge clk50_clk);
      rst_reset_n = 1'b1;
      @(negedge clk50_clk);

      // 1: reset state
      check("t1_sync_out", 32'(sync_out), 32'd0);
      check("t1_sync_ch", 32'(sync_ch), 32'd0);
      check("t1_irq", 32'(irq), 32'd0);
      check("t1_readdata", avs_readdata, 32'd0);
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), rd);
         check($sformatf("t1_reg%0d", a), rd, 32'd0);
      end
      // Same-cycle write and read of one address returns the old value
      avs_address   = A_MASTER_W;
      avs_writedata = 32'd4;
      avs_write     = 1'b1;
      avs_read      = 1'b1;
      @(negedge clk50_clk);
      avs_write = 1'b0;
      avs_read  = 1'b0;
      check("t1_rw_same_cycle", avs_readdata, 32'd0);
      bus_read(A_MASTER_W, rd);
      check("t1_master_w", rd, 32'd4);

      // 2: basic internal cycle, period 10, widths 4/2, 4 pulses
      bus_write(A_PERIOD, 32'd10);
      bus_write(A_PULSE_W, 32'd2);
      bus_write(A_N_PULSES, 32'd4);
      bus_write(A_CH_EN, 32'hFF);
      bus_write(A_CTRL, 32'h9);
      for (int t = 0; t < 120; t++) begin
         @(negedge clk50_clk);
         chk_int("t2", t, 10, 4, 4, 4, 2, 8'hFF, 1'b1);
      end
      @(negedge clk50_clk);
      bus_read(A_CYCLE_CNT, rd);
      check("t2_cycle_cnt", rd, 32'd3);

      // 3: normal width clamped to PERIOD-1, then PERIOD=1 gives cfg_err
      bus_write(A_CTRL, 32'h0);
      bus_write(A_PULSE_W, 32'd20);
      bus_write(A_CTRL, 32'h9);
      for (int t = 0; t < 40; t++) begin
         @(negedge clk50_clk);
         chk_int("t3", t, 10, 4, 4, 4, 20, 8'hFF, 1'b1);
      end
      bus_write(A_PERIOD, 32'd1);
      repeat (50) @(negedge clk50_clk);
      check("t3_err_sync_out", 32'(sync_out), 32'd0);
      check("t3_err_sync_ch", 32'(sync_ch), 32'd0);
      check("t3_err_irq", 32'(irq), 32'd0);
      bus_read(A_STATUS, rd);
      check("t3_status", rd, 32'h2);

      // 4: mid-cycle MASTER_W and CH_EN writes
      bus_write(A_CTRL, 32'h0);
      bus_write(A_PERIOD, 32'd10);
      bus_write(A_PULSE_W, 32'd2);
      bus_write(A_CTRL, 32'h9);
      for (int t = 0; t < 120; t++) begin
         if (t == 15) bus_write(A_MASTER_W, 32'd6);
         else if (t == 20) bus_write(A_CH_EN, 32'h05);
         else @(negedge clk50_clk);
         chk_int("t4", t, 10, 4, 4, 6, 2, (t < 20) ? 8'hFF : 8'h05, 1'b1);
      end
      bus_read(A_STATUS, rd);
      check("t4_status_busy_noerr", rd & 32'h3, 32'h1);

      // 5: external mode, 2 pulses, edges 100 clocks apart
      bus_write(A_CTRL, 32'h0);
      bus_write(A_MASTER_W, 32'd4);
      bus_write(A_N_PULSES, 32'd2);
      bus_write(A_CTRL, 32'hB);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk50_clk);
         check($sformatf("t5_wait_out_%0d", k), 32'(sync_out), 32'd0);
      end
      for (int e = 0; e < 3; e++) begin
         sync_in = 1'b1;
         w = ((e % 2) == 0) ? 4 : 2;
         for (int k = 1; k <= 100; k++) begin
            @(negedge clk50_clk);
            if (k == 10) sync_in = 1'b0;
            check($sformatf("t5_out_e%0d_k%0d", e, k), 32'(sync_out),
                  32'((k >= 3) && (k < 3 + w)));
            check($sformatf("t5_irq_e%0d_k%0d", e, k), 32'(irq),
                  32'((k == 3) && ((e % 2) == 0)));
         end
      end

      // 6: inverted polarity, stop mid-master-pulse at counter 2
      bus_write(A_CTRL, 32'h0);
      bus_write(A_CH_EN, 32'hFF);
      bus_write(A_CTRL, 32'h5);
      check("t6_idle_inverted", 32'(sync_out), 32'd1);
      for (int t = 0; t < 43; t++) begin
         @(negedge clk50_clk);
         check($sformatf("t6_out_t%0d", t), 32'(sync_out),
               32'(!model_pulse(t, 10, 2, 4, 4, 2)));
      end
      bus_write(A_CTRL, 32'h4);
      check("t6_first_edge_still_active", 32'(sync_out), 32'd0);
      @(negedge clk50_clk);
      check("t6_stop_sync_out", 32'(sync_out), 32'd1);
      check("t6_stop_sync_ch", 32'(sync_ch), 32'hFF);
      check("t6_stop_irq", 32'(irq), 32'd0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk50_clk);
         check($sformatf("t6_hold_%0d", k), 32'(sync_out), 32'd1);
      end
      bus_read(A_STATUS, rd);
      check("t6_status", rd, 32'd0);
      bus_read(A_CYCLE_CNT, rd);
      check("t6_cycle_cnt", rd, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
